eye_centroid: RTL
=================

# eye_centroid

Frame-level pupil centroid engine. After a frame's binarized rows (bit = pixel above threshold) are written to the row memory bank, it reads the completed bank row by row. It accumulates pixel count, ΣX and ΣY, and divides to produce the centroid (CX, CY). It sits directly downstream of the Camera Link capture stage and feeds the tracking result to the output/VGA overlay logic.

## Interface
- ADDR_WIDTH, 11: row-address and coordinate width.
- MDATA_WIDTH, 640: bits per memory row (pixels per line). Must be divisible by SEG_WIDTH.
- N_ROWS, 480: rows scanned per frame.
- SEG_WIDTH, 16: pixels processed per ACCUM cycle.
- ACC_WIDTH, 32: width of the count, ΣX and ΣY accumulators, and of the divider.
- CCLK  in  1  clock; the single clock of the block.
- RST_N  in  1  asynchronous, active-low reset.
- iSTART  in  1  one-cycle pulse: a frame is complete; ignored while oBUSY=1.
- iMEM_SEL  in  1  capture bank select, sampled when iSTART is accepted.
- oBUSY  out  1  high from the cycle after an accepted iSTART through the oVALID cycle.
- oRD_BANK  out  1  bank to read: the inverse of the sampled iMEM_SEL, held for the whole frame.
- oRD_EN  out  1  read strobe; data returns on iRD_DATA one cycle later.
- oRD_ROW  out  ADDR_WIDTH  row address, valid while oRD_EN=1.
- iRD_DATA  in  MDATA_WIDTH  row word; bit k is pixel x=k.
- oVALID  out  1  one-cycle result strobe.
- oFOUND  out  1  1 if count>0.
- oCX, oCY  out  ADDR_WIDTH each  centroid, floor(ΣX/count) and floor(ΣY/count).
- oCOUNT  out  ACC_WIDTH  number of set pixels in the frame.

## Operation
- States: IDLE, FETCH, LOAD, ACCUM, DIV_X, DIV_Y, DONE.
- IDLE
  - On iSTART: clear the accumulators, set row=0, latch oRD_BANK=~iMEM_SEL, then go to FETCH.
- FETCH (1 cycle)
  - oRD_EN=1, oRD_ROW=row. Go to LOAD.
- LOAD (1 cycle)
  - Capture iRD_DATA into a shift register, set seg=0. Go to ACCUM.
- ACCUM (MDATA_WIDTH/SEG_WIDTH cycles)
  - Operate on the low SEG_WIDTH bits b[j].
  - Compute p = popcount(b) and w = Σ j·b[j].
  - Update count += p; ΣX += p·(seg·SEG_WIDTH) + w; ΣY += p·row.
  - Shift right by SEG_WIDTH and increment seg.
  - After the last segment: if row = N_ROWS−1, go to DIV_X, or to DONE when count=0. Otherwise row++ and go to FETCH.
- DIV_X, DIV_Y (ACC_WIDTH cycles each)
  - Restoring shift-subtract unsigned divide of ΣX (then ΣY) by count, one quotient bit per cycle.
  - The quotient is truncated (floor) to ADDR_WIDTH bits, which is lossless since CX<MDATA_WIDTH and CY<N_ROWS.
  - A single divider instance is reused for both.
- DONE (1 cycle)
  - oVALID=1; update oCX, oCY, oCOUNT and oFOUND. Return to IDLE.
  - When count=0: oFOUND=0, oCX=oCY=0, oCOUNT=0, and no division is performed.
- Result registers hold their values until the next oVALID.
- Accumulator width rules:
  - Defaults give max count 307200, ΣX ≤ 98,150,400 and ΣY ≤ 73,574,400, all < 2^ACC_WIDTH.
  - No saturation logic is required for legal parameter sets.
- iSTART during oBUSY is dropped with no side effect; it is neither queued nor restarts the scan.
- iMEM_SEL changes mid-frame have no effect on oRD_BANK.

## Timing
- Reset values: oBUSY=0, oRD_BANK=0, oRD_EN=0, oRD_ROW=0, oVALID=0, oFOUND=0, oCX=0, oCY=0, oCOUNT=0; state=IDLE.
- Assertion of RST_N mid-frame aborts immediately: no oVALID, and outputs return to reset values.
- Cycle numbering: iSTART is sampled on edge 0; FETCH of row 0 is the cycle after.
- Per row: 2 + MDATA_WIDTH/SEG_WIDTH cycles, which is 42 at defaults.
- oRD_EN is high exactly one cycle per row, for N_ROWS pulses total, with oRD_ROW = 0,1,…,N_ROWS−1 in order.
- Latency from the iSTART cycle to the oVALID cycle:
  - count>0: N_ROWS·(2+MDATA_WIDTH/SEG_WIDTH) + 2·ACC_WIDTH + 1, which is 20225 at defaults.
  - count=0: N_ROWS·(2+MDATA_WIDTH/SEG_WIDTH) + 1, which is 20161.
- oBUSY falls in the cycle after oVALID. A new iSTART is accepted in that same cycle.

## Test plan
- All-zero memory, iSTART:
  - oVALID at cycle 20161 with oFOUND=0, CX=CY=0, COUNT=0.
  - Exactly 480 oRD_EN pulses, addresses 0..479.
- Single pixel at x=5, y=3 → CX=5, CY=3, COUNT=1, oFOUND=1, oVALID at cycle 20225.
- All-ones frame → COUNT=307200, CX=319, CY=239 (floors of 319.5 and 239.5).
- Rectangle x=100..103, y=200..201 → COUNT=8, CX=101, CY=200.
  - Repeat with x=14..17 so the block straddles a segment boundary → CX=15.
- iMEM_SEL=1 at iSTART → oRD_BANK=0 for the whole frame.
  - A second iSTART at cycle 500 is ignored: a single oVALID, result unchanged.
- RST_N low at cycle 8000:
  - All outputs go to 0 and no oVALID occurs.
  - After release, a new iSTART yields the correct centroid for the loaded frame.

Source files
------------

// File: rtl/eye_centroid_if.sv
// Bus bundle between the centroid engine and its surroundings: frame start,
// row-memory read port and the centroid result.
//
// Handshake: iSTART is a one-cycle request that is accepted only when oBUSY=0
// (there is no ready back-pressure; a request while busy is dropped).
// oRD_EN is a fire-and-forget read strobe whose data must appear on iRD_DATA
// on the following cycle. oVALID is a one-cycle result strobe with no ready;
// the result registers hold until the next oVALID.
interface eye_centroid_if #(
  parameter int ADDR_WIDTH  = 11,
  parameter int MDATA_WIDTH = 640,
  parameter int ACC_WIDTH   = 32
);
  logic                   iSTART;
  logic                   iMEM_SEL;
  logic                   oBUSY;
  logic                   oRD_BANK;
  logic                   oRD_EN;
  logic [ADDR_WIDTH-1:0]  oRD_ROW;
  logic [MDATA_WIDTH-1:0] iRD_DATA;
  logic                   oVALID;
  logic                   oFOUND;
  logic [ADDR_WIDTH-1:0]  oCX;
  logic [ADDR_WIDTH-1:0]  oCY;
  logic [ACC_WIDTH-1:0]   oCOUNT;

  // Upstream side: capture control and row memory
  modport master (
    output iSTART, iMEM_SEL, iRD_DATA,
    input  oBUSY, oRD_BANK, oRD_EN, oRD_ROW, oVALID, oFOUND, oCX, oCY, oCOUNT
  );

  // Centroid engine side
  modport slave (
    input  iSTART, iMEM_SEL, iRD_DATA,
    output oBUSY, oRD_BANK, oRD_EN, oRD_ROW, oVALID, oFOUND, oCX, oCY, oCOUNT
  );
endinterface

// File: rtl/eye_centroid.sv
// Frame-level pupil centroid engine. Scans the completed row bank one row at
// a time, accumulates pixel count, sum of X and sum of Y a segment at a time,
// then divides with one shared restoring divider to get (CX, CY).
module eye_centroid #(
  parameter int ADDR_WIDTH  = 11,
  parameter int MDATA_WIDTH = 640,
  parameter int N_ROWS      = 480,
  parameter int SEG_WIDTH   = 16,
  parameter int ACC_WIDTH   = 32
) (
  input  logic          CCLK,
  input  logic          RST_N,
  eye_centroid_if.slave bus,
  output logic [2:0]    oDBG_STATE
);

  localparam int NSEG = MDATA_WIDTH / SEG_WIDTH;
  localparam int SEGW = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam int DIVW = $clog2(ACC_WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_ACCUM = 3'd3,
    S_DIV_X = 3'd4,
    S_DIV_Y = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t                 r_state;
  logic                   r_busy;
  logic                   r_rd_bank;
  logic                   r_rd_en;
  logic [ADDR_WIDTH-1:0]  r_row;
  logic [MDATA_WIDTH-1:0] r_shreg;
  logic [SEGW-1:0]        r_seg;
  logic [ACC_WIDTH-1:0]   r_count;
  logic [ACC_WIDTH-1:0]   r_sx;
  logic [ACC_WIDTH-1:0]   r_sy;
  logic [ACC_WIDTH-1:0]   r_rem;
  logic [ACC_WIDTH-1:0]   r_quo;
  logic [DIVW-1:0]        r_bit;
  logic [ADDR_WIDTH-1:0]  r_cx_tmp;
  logic                   r_valid;
  logic                   r_found;
  logic [ADDR_WIDTH-1:0]  r_cx;
  logic [ADDR_WIDTH-1:0]  r_cy;
  logic [ACC_WIDTH-1:0]   r_ocount;

  logic [ACC_WIDTH-1:0]   w_pop;
  logic [ACC_WIDTH-1:0]   w_wsum;
  logic [ACC_WIDTH-1:0]   w_xbase;
  logic [ACC_WIDTH-1:0]   w_count_n;
  logic [ACC_WIDTH-1:0]   w_sx_n;
  logic [ACC_WIDTH-1:0]   w_sy_n;
  logic [ACC_WIDTH:0]     w_rem_sh;
  logic                   w_sub_ok;
  logic [ACC_WIDTH-1:0]   w_rem_n;
  logic [ACC_WIDTH-1:0]   w_quo_n;

  // Segment statistics: popcount and in-segment position sum of the low bits,
  // plus the accumulator values after this segment is folded in.
  always_comb begin
    w_pop  = '0;
    w_wsum = '0;
    for (int j = 0; j < SEG_WIDTH; j++) begin
      if (r_shreg[j]) begin
        w_pop  = w_pop + ACC_WIDTH'(1);
        w_wsum = w_wsum + ACC_WIDTH'(j);
      end
    end
    w_xbase   = ACC_WIDTH'(r_seg) * ACC_WIDTH'(SEG_WIDTH);
    w_count_n = r_count + w_pop;
    w_sx_n    = r_sx + w_pop * w_xbase + w_wsum;
    w_sy_n    = r_sy + w_pop * ACC_WIDTH'(r_row);
  end

  // One restoring divide step: dividend shifts out of r_quo into the
  // remainder, quotient bits shift in from the bottom. Divisor is r_count.
  always_comb begin
    w_rem_sh = {r_rem, r_quo[ACC_WIDTH-1]};
    w_sub_ok = (w_rem_sh >= {1'b0, r_count});
    w_rem_n  = w_sub_ok ? ACC_WIDTH'(w_rem_sh - {1'b0, r_count})
                        : ACC_WIDTH'(w_rem_sh);
    w_quo_n  = {r_quo[ACC_WIDTH-2:0], w_sub_ok};
  end

  // Main controller: scan, accumulate, divide and publish the result.
  always_ff @(posedge CCLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_rd_bank <= 1'b0;
      r_rd_en   <= 1'b0;
      r_row     <= '0;
      r_shreg   <= '0;
      r_seg     <= '0;
      r_count   <= '0;
      r_sx      <= '0;
      r_sy      <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_bit     <= '0;
      r_cx_tmp  <= '0;
      r_valid   <= 1'b0;
      r_found   <= 1'b0;
      r_cx      <= '0;
      r_cy      <= '0;
      r_ocount  <= '0;
    end else begin
      r_valid <= 1'b0;
      r_rd_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.iSTART) begin
            r_busy    <= 1'b1;
            r_rd_bank <= ~bus.iMEM_SEL;
            r_count   <= '0;
            r_sx      <= '0;
            r_sy      <= '0;
            r_row     <= '0;
            r_rd_en   <= 1'b1;
            r_state   <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_shreg <= bus.iRD_DATA;
          r_seg   <= '0;
          r_state <= S_ACCUM;
        end
        S_ACCUM: begin
          r_count <= w_count_n;
          r_sx    <= w_sx_n;
          r_sy    <= w_sy_n;
          r_shreg <= r_shreg >> SEG_WIDTH;
          r_seg   <= r_seg + 1'b1;
          if (r_seg == SEGW'(NSEG - 1)) begin
            if (r_row == ADDR_WIDTH'(N_ROWS - 1)) begin
              if (w_count_n == '0) begin
                // Empty frame: publish a cleared result without dividing
                r_valid  <= 1'b1;
                r_found  <= 1'b0;
                r_cx     <= '0;
                r_cy     <= '0;
                r_ocount <= '0;
                r_state  <= S_DONE;
              end else begin
                r_quo   <= w_sx_n;
                r_rem   <= '0;
                r_bit   <= '0;
                r_state <= S_DIV_X;
              end
            end else begin
              r_row   <= r_row + 1'b1;
              r_rd_en <= 1'b1;
              r_state <= S_FETCH;
            end
          end
        end
        S_DIV_X: begin
          r_quo <= w_quo_n;
          r_rem <= w_rem_n;
          r_bit <= r_bit + 1'b1;
          if (r_bit == DIVW'(ACC_WIDTH - 1)) begin
            // Quotient fits in ADDR_WIDTH since CX < MDATA_WIDTH
            r_cx_tmp <= w_quo_n[ADDR_WIDTH-1:0];
            r_quo    <= r_sy;
            r_rem    <= '0;
            r_bit    <= '0;
            r_state  <= S_DIV_Y;
          end
        end
        S_DIV_Y: begin
          r_quo <= w_quo_n;
          r_rem <= w_rem_n;
          r_bit <= r_bit + 1'b1;
          if (r_bit == DIVW'(ACC_WIDTH - 1)) begin
            r_valid  <= 1'b1;
            r_found  <= 1'b1;
            r_cx     <= r_cx_tmp;
            r_cy     <= w_quo_n[ADDR_WIDTH-1:0];
            r_ocount <= r_count;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.oBUSY    = r_busy;
  assign bus.oRD_BANK = r_rd_bank;
  assign bus.oRD_EN   = r_rd_en;
  assign bus.oRD_ROW  = r_row;
  assign bus.oVALID   = r_valid;
  assign bus.oFOUND   = r_found;
  assign bus.oCX      = r_cx;
  assign bus.oCY      = r_cy;
  assign bus.oCOUNT   = r_ocount;
  assign oDBG_STATE   = r_state;

endmodule
